// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES definitions: FSM encoding, S-box table, GF(2^8) xtime and NK->NR helper.
// Reused by the iterative encrypt core and its round datapath.
package aes_cipher_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Table is written in FIPS-197 reading order, so entry for byte b lives at index 255-b (= ~b).
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[~b];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_to_nr(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round) and AddRoundKey. Byte 0 of the state sits at [127:120].
module aes_round
    import aes_cipher_iter_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         final_rnd,
    output logic [127:0] state_out
);

    // Byte index i = 4*column + row.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_in[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates left by r columns.
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
            // Output row r = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
            assign mc[4*c+r] = xtime(sr[4*c+r]) ^ xtime(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                             ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign state_out[127-8*i -: 8] = (final_rnd ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock, valid/ready on both sides.
// The expanded key bus is sampled every round and must stay stable for the whole block.
module aes_cipher_iter
    import aes_cipher_iter_pkg::*;
#(
    parameter  int NK = 4,
    localparam int NR = nk_to_nr(NK),
    localparam int KW = 128 * (NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic [KW-1:0] w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_cipher_iter: NK must be 4, 6 or 8");
    end

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] st_q, st_d;
    logic [127:0] data_q, data_d;
    logic [127:0] rk_tab [NR+1];
    logic [127:0] rnd_out;
    logic         last;

    // Round key r = words 4r..4r+3, word 4r landing on state column 0 (MSBs).
    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign rk_tab[r] = {w[32*(4*r)   +: 32], w[32*(4*r+1) +: 32],
                            w[32*(4*r+2) +: 32], w[32*(4*r+3) +: 32]};
    end

    assign last = (round_q == 4'(NR));

    aes_round u_round (
        .state_in  (st_q),
        .rk        (rk_tab[round_q]),
        .final_rnd (last),
        .state_out (rnd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            st_q    <= '0;
            data_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            st_q    <= st_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        st_d    = st_q;
        data_d  = data_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data ^ rk_tab[0];
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                st_d = rnd_out;
                if (last) begin
                    // Output register is separate so ciphertext survives the next accept.
                    data_d  = rnd_out;
                    round_d = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
    assign out_data  = data_q;

endmodule
